// File: rtl/rpi_irq_pkg.sv
// rtl/rpi_irq_pkg.sv - shared types, mode constants and width helper for the interrupt clock generator
package rpi_irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rpi_irq_channel.sv
// rtl/rpi_irq_channel.sv - one interrupt clock channel: input synchronisers, edge detect, FSM, counters
module rpi_irq_channel
  import rpi_irq_pkg::*;
#(
  parameter int HALF_PERIOD = 32,
  parameter int BURST_LEN   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_req_i,
  input  logic irq_mode_i,
  input  logic irq_ack_i,
  output logic clk_out_o,
  output logic busy_o,
  output logic done_pulse_o
);

  localparam int HCW = cnt_width(HALF_PERIOD);
  localparam int PCW = cnt_width(BURST_LEN);
  localparam logic [HCW-1:0] HALF_LAST  = HCW'(HALF_PERIOD - 1);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(BURST_LEN - 1);

  logic [SYNC_STAGES-1:0] req_sync_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   req_dly_q;
  logic                   ack_dly_q;
  logic                   req_s;
  logic                   ack_s;
  logic                   req_rise;
  logic                   ack_rise;

  state_e                 state_q, state_d;
  logic [HCW-1:0]         half_q, half_d;
  logic [PCW-1:0]         pulse_q, pulse_d;
  logic                   mode_q, mode_d;
  logic                   done_d;
  logic                   clk_out_q;
  logic                   busy_q;
  logic                   done_q;

  assign req_s    = req_sync_q[SYNC_STAGES-1];
  assign ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign req_rise = req_s & ~req_dly_q;
  assign ack_rise = ack_s & ~ack_dly_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_sync_q <= '0;
      ack_sync_q <= '0;
      req_dly_q  <= 1'b0;
      ack_dly_q  <= 1'b0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], irq_req_i};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], irq_ack_i};
      req_dly_q  <= req_s;
      ack_dly_q  <= ack_s;
    end
  end

  // Abort on request drop outranks acknowledge, which outranks terminal count.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    pulse_d = pulse_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_rise) begin
          state_d = HIGH;
          half_d  = '0;
          pulse_d = '0;
          mode_d  = irq_mode_i;
        end
      end
      HIGH, LOW: begin
        if (!req_s) begin
          state_d = IDLE;
          half_d  = '0;
        end else if (ack_rise) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (half_q == HALF_LAST) begin
          half_d = '0;
          if (state_q == HIGH) begin
            state_d = LOW;
          end else if (mode_q == MODE_BURST && pulse_q == PULSE_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = HIGH;
            if (pulse_q != PULSE_LAST) pulse_d = pulse_q + 1'b1;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      DONE: begin
        if (!req_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      half_q    <= '0;
      pulse_q   <= '0;
      mode_q    <= MODE_CONT;
      clk_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      pulse_q   <= pulse_d;
      mode_q    <= mode_d;
      clk_out_q <= (state_d == HIGH);
      busy_q    <= (state_d == HIGH) || (state_d == LOW);
      done_q    <= done_d;
    end
  end

  assign clk_out_o    = clk_out_q;
  assign busy_o       = busy_q;
  assign done_pulse_o = done_q;

endmodule

// File: rtl/rpi_irq_clk_gen.sv
// rtl/rpi_irq_clk_gen.sv - multi-channel interrupt clock generator top, one independent channel per bit
module rpi_irq_clk_gen
  import rpi_irq_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int HALF_PERIOD = 32,
  parameter int BURST_LEN   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] irq_req,
  input  logic [NUM_CH-1:0] irq_mode,
  input  logic [NUM_CH-1:0] irq_ack,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done_pulse
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rpi_irq_channel #(
      .HALF_PERIOD (HALF_PERIOD),
      .BURST_LEN   (BURST_LEN),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk_i        (clk_in),
      .rst_ni       (rst_n),
      .irq_req_i    (irq_req[g]),
      .irq_mode_i   (irq_mode[g]),
      .irq_ack_i    (irq_ack[g]),
      .clk_out_o    (clk_out[g]),
      .busy_o       (busy[g]),
      .done_pulse_o (done_pulse[g])
    );
  end

endmodule

// File: tb/tb_rpi_irq_clk_gen.sv
// tb/tb_rpi_irq_clk_gen.sv - directed table-driven bench for rpi_irq_clk_gen
module tb_rpi_irq_clk_gen;

  localparam int NCH = 2;

  logic           clk_in = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] irq_req;
  logic [NCH-1:0] irq_mode;
  logic [NCH-1:0] irq_ack;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done_pulse;

  always #5 clk_in = ~clk_in;

  rpi_irq_clk_gen #(
    .NUM_CH      (NCH),
    .HALF_PERIOD (4),
    .BURST_LEN   (3),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .irq_req    (irq_req),
    .irq_mode   (irq_mode),
    .irq_ack    (irq_ack),
    .clk_out    (clk_out),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  typedef struct {
    int         cyc;
    logic [1:0] req;
    logic [1:0] ack;
    logic [1:0] mode;
  } ev_t;

  // Expected non-zero outputs of one channel over an inclusive cycle range.
  typedef struct {
    int   lo;
    int   hi;
    int   ch;
    logic clk;
    logic busy;
    logic done;
  } seg_t;

  ev_t  evs[$];
  seg_t segs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add_ev(int c, logic [1:0] r, logic [1:0] a, logic [1:0] m);
    evs.push_back('{cyc: c, req: r, ack: a, mode: m});
  endfunction

  function automatic void add_seg(int lo, int hi, int ch, logic c, logic b, logic d);
    segs.push_back('{lo: lo, hi: hi, ch: ch, clk: c, busy: b, done: d});
  endfunction

  function automatic void add_burst(int ch, int s);
    for (int k = 0; k < 6; k++) add_seg(s + 3 + 4 * k, s + 6 + 4 * k, ch, (k % 2 == 0), 1'b1, 1'b0);
    add_seg(s + 27, s + 27, ch, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic void add_cont(int ch, int s, int last);
    for (int k = 0; s + 3 + 4 * k <= last; k++) begin
      add_seg(s + 3 + 4 * k, (s + 6 + 4 * k > last) ? last : s + 6 + 4 * k, ch,
              (k % 2 == 0), 1'b1, 1'b0);
    end
  endfunction

  function automatic logic [2:0] expect_at(int c, int ch);
    foreach (segs[i]) begin
      if (segs[i].ch == ch && c >= segs[i].lo && c <= segs[i].hi)
        return {segs[i].clk, segs[i].busy, segs[i].done};
    end
    return 3'b000;
  endfunction

  task automatic check(input string name, input int c, input int ch,
                       input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d ch=%0d got=%b expected=%b", name, c, ch, act, exp);
    end
  endtask

  // Cycle c starts at the c-th rising edge after the call; inputs change 1 time unit later.
  task automatic run(input string name, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk_in);
      #1;
      foreach (evs[i]) begin
        if (evs[i].cyc == c) begin
          irq_req  = evs[i].req;
          irq_ack  = evs[i].ack;
          irq_mode = evs[i].mode;
        end
      end
      #3;
      for (int ch = 0; ch < NCH; ch++) begin
        check(name, c, ch, {3'b000, clk_out[ch], busy[ch], done_pulse[ch]},
              {3'b000, expect_at(c, ch)});
      end
    end
    evs.delete();
    segs.delete();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    irq_req  = '0;
    irq_ack  = '0;
    irq_mode = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_state", 0, -1, {clk_out, busy, done_pulse}, 6'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    add_ev(0, 2'b01, 2'b00, 2'b01);
    add_ev(40, 2'b00, 2'b00, 2'b01);
    add_burst(0, 0);
    run("burst", 45);

    do_reset();
    add_ev(0, 2'b01, 2'b00, 2'b00);
    add_ev(100, 2'b00, 2'b00, 2'b00);
    add_cont(0, 0, 102);
    run("continuous", 110);

    do_reset();
    add_ev(0, 2'b01, 2'b00, 2'b01);
    add_ev(12, 2'b01, 2'b01, 2'b01);
    add_ev(13, 2'b01, 2'b00, 2'b01);
    add_ev(40, 2'b00, 2'b00, 2'b01);
    add_ev(45, 2'b01, 2'b00, 2'b01);
    add_seg(3, 6, 0, 1'b1, 1'b1, 1'b0);
    add_seg(7, 10, 0, 1'b0, 1'b1, 1'b0);
    add_seg(11, 14, 0, 1'b1, 1'b1, 1'b0);
    add_seg(15, 15, 0, 1'b0, 1'b0, 1'b1);
    add_seg(48, 51, 0, 1'b1, 1'b1, 1'b0);
    add_seg(52, 55, 0, 1'b0, 1'b1, 1'b0);
    run("ack_mid_burst", 56);

    do_reset();
    add_ev(0, 2'b01, 2'b00, 2'b01);
    add_ev(24, 2'b01, 2'b01, 2'b01);
    add_ev(26, 2'b01, 2'b00, 2'b01);
    add_burst(0, 0);
    run("ack_at_terminal", 40);

    do_reset();
    add_ev(0, 2'b01, 2'b00, 2'b01);
    add_ev(12, 2'b00, 2'b01, 2'b01);
    add_ev(14, 2'b00, 2'b00, 2'b01);
    add_seg(3, 6, 0, 1'b1, 1'b1, 1'b0);
    add_seg(7, 10, 0, 1'b0, 1'b1, 1'b0);
    add_seg(11, 14, 0, 1'b1, 1'b1, 1'b0);
    run("abort_beats_ack", 25);

    do_reset();
    add_ev(0, 2'b11, 2'b00, 2'b01);
    for (int ch = 0; ch < NCH; ch++) begin
      add_seg(3, 6, ch, 1'b1, 1'b1, 1'b0);
      add_seg(7, 10, ch, 1'b0, 1'b1, 1'b0);
      add_seg(11, 12, ch, 1'b1, 1'b1, 1'b0);
    end
    run("rst_mid_pre", 13);
    @(posedge clk_in);
    #1;
    check("rst_mid_busy", 13, -1, {clk_out, busy, done_pulse}, 6'b111100);
    rst_n   = 1'b0;
    irq_req = 2'b00;
    #1;
    check("rst_mid_async", 13, -1, {clk_out, busy, done_pulse}, 6'b0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    run("rst_mid_quiet", 6);
    add_ev(0, 2'b01, 2'b00, 2'b01);
    add_seg(3, 6, 0, 1'b1, 1'b1, 1'b0);
    add_seg(7, 8, 0, 1'b0, 1'b1, 1'b0);
    run("rst_mid_restart", 9);

    do_reset();
    add_ev(0, 2'b01, 2'b00, 2'b01);
    add_ev(5, 2'b11, 2'b00, 2'b01);
    add_burst(0, 0);
    add_cont(1, 5, 44);
    run("independence", 45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpi_irq_clk_gen.md
Name: rpi_irq_clk_gen

Overview:
- Multi-channel interrupt clock generator driving Raspberry Pi GPIO lines from the 50 MHz codec-board clock.
- A rising edge on a channel request starts a square-wave "interrupt clock" on that channel.
- The wave runs continuously or as a fixed-length burst, and ends on request drop, Pi acknowledge, or burst completion.
- Parametrised in channel count, half-period, burst length and synchroniser depth. Adds burst mode, acknowledge termination, status and completion strobes.

Parameters:
- NUM_CH, 2, number of independent channels
- HALF_PERIOD, 32, clk_in cycles per output half-period; minimum 1 (output period = 2*HALF_PERIOD)
- BURST_LEN, 8, output pulses per burst in burst mode; minimum 1
- SYNC_STAGES, 2, flop stages on irq_req and irq_ack; minimum 2

Ports:
- clk_in  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- irq_req  input  NUM_CH  per-channel level request; may be asynchronous to clk_in
- irq_mode  input  NUM_CH  per-channel mode: 0 = continuous, 1 = burst
- irq_ack  input  NUM_CH  per-channel acknowledge from the Pi; asynchronous
- clk_out  output  NUM_CH  per-channel interrupt clock to the Pi; registered
- busy  output  NUM_CH  channel is in HIGH or LOW
- done_pulse  output  NUM_CH  one-cycle strobe on normal termination

Behaviour:
- One clock domain (clk_in). Reset is asynchronous and active-low (rst_n).
- Reset: every flop clears immediately, including sync chains, counters, state (IDLE), clk_out, busy and done_pulse. Release is synchronous to the clk_in edge.
- Synchronisation: irq_req and irq_ack each pass through SYNC_STAGES flops. Edge detection uses the synced value against a one-cycle-delayed copy.
- Per-channel FSM states: IDLE, HIGH, LOW, DONE. clk_out = 1 only in HIGH, registered from next-state.
- IDLE -> HIGH on a synced irq_req rising edge.
  - Half-counter clears; pulse counter clears; irq_mode is latched.
  - Latency from raw irq_req rise to clk_out high: SYNC_STAGES+1 cycles.
- HIGH: half-counter increments each cycle. At HALF_PERIOD-1: -> LOW, counter clears.
- LOW: at HALF_PERIOD-1:
  - latched mode = burst and pulse counter = BURST_LEN-1 -> DONE, done_pulse = 1 for that one cycle;
  - otherwise pulse counter increments, -> HIGH.
- Continuous mode never terminates on count. The pulse counter is held, not wrapped.
- Synced irq_ack rising edge in HIGH or LOW -> DONE, clk_out = 0, done_pulse = 1 for one cycle.
- Synced irq_req low in HIGH or LOW -> IDLE, clk_out = 0, no done_pulse (abort). A truncated high half-period is permitted.
- DONE: clk_out = 0. Stays until synced irq_req is low, then -> IDLE. A new rising edge requires irq_req to drop and rise again.
- Simultaneous events, priority: req-low abort > ack > terminal count. Ack coinciding with terminal count gives exactly one done_pulse.
- irq_mode changes while busy are ignored until the next start.
- Counter widths:
  - half-counter $clog2(HALF_PERIOD) bits, minimum 1;
  - pulse counter $clog2(BURST_LEN) bits, minimum 1;
  - no overflow is reachable.
- HALF_PERIOD = 1: clk_out toggles every cycle.
- Channels are fully independent; no shared state.

Decomposition:
- Package rpi_irq_pkg holds:
  - state enum {IDLE, HIGH, LOW, DONE};
  - mode constants MODE_CONT = 1'b0, MODE_BURST = 1'b1;
  - helper function for counter width (clog2, minimum 1).
- Sub-module rpi_irq_channel contains the sync chains, edge detect, FSM and both counters for one channel.
- Top rpi_irq_clk_gen instantiates NUM_CH copies in a generate loop and concatenates outputs.

Test Plan:
Common settings: HALF_PERIOD=4, BURST_LEN=3, SYNC_STAGES=2; irq_req ch0 rises at cycle 0.
- Burst: irq_mode[0]=1 -> clk_out[0] high cycles 3-6, low 7-10, high 11-14, low 15-18, high 19-22, low 23-26. done_pulse[0] high only at cycle 27; busy[0] low from 27. clk_out[0] stays 0 while irq_req is held.
- Continuous: irq_mode[0]=0, irq_req high 100 cycles -> period-8 square wave, no done_pulse. irq_req drop -> clk_out[0] 0 within 3 cycles, busy 0, state IDLE.
- Ack mid-burst: irq_ack[0] pulse at cycle 12 -> clk_out[0] 0 at cycle 15, done_pulse once. A further irq_req rise is ignored until irq_req goes low first.
- Priority: irq_ack timed to reach sync output on cycle 26 -> exactly one done_pulse. irq_req low and irq_ack on the same synced cycle -> IDLE, no done_pulse.
- Reset mid-operation: rst_n low at cycle 13 with both channels busy -> all outputs 0 immediately (asynchronous). After release, no output until a fresh irq_req edge.
- Independence: ch0 burst and ch1 continuous started 5 cycles apart -> waveforms are exact time-shifted copies of the single-channel results.
